// File: rtl/stb_axi_wr_issuer_if.sv
// Store-entry input and AXI4 write-channel bundle for stb_axi_wr_issuer.
// master: the issuer's own view; slave: the store source plus the AXI memory side.
interface stb_axi_wr_issuer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic                    s_valid;
    logic                    s_ready;
    logic [ADDR_WIDTH-1:0]   s_addr;
    logic [DATA_WIDTH-1:0]   s_data;
    logic [DATA_WIDTH/8-1:0] s_strb;

    logic                    m_awvalid;
    logic                    m_awready;
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;

    logic                    m_wvalid;
    logic                    m_wready;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wlast;

    logic                    m_bvalid;
    logic                    m_bready;
    logic [1:0]              m_bresp;

    modport master (
        input  s_valid, s_addr, s_data, s_strb,
        output s_ready,
        output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bresp,
        output m_bready
    );

    modport slave (
        output s_valid, s_addr, s_data, s_strb,
        input  s_ready,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bresp,
        input  m_bready
    );
endinterface

// File: rtl/stb_axi_wr_issuer.sv
// Store-buffer write issuer: FIFO of store entries drained as coalesced AXI4 INCR bursts.
// Optional B-channel watchdog is enabled by defining STB_WR_TIMEOUT_EN.
module stb_axi_wr_issuer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 8,
    parameter int MAX_BURST   = 4,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                clk,
    input  logic                rst,
    stb_axi_wr_issuer_if.master bus,
    output logic                busy,
    output logic                resp_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_W);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [STRB_W-1:0]     mem_strb [DEPTH];
    logic [DEPTH-1:0]      mem_cont;

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] last_push_addr;
    logic                  last_push_valid;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]            awlen_q;
    logic [7:0]            beats_left;
    logic [7:0]            len_calc;

    logic                  push, pop, latch, push_cont, resp_err_nx, timeout_hit;
    logic [ADDR_WIDTH-1:0] push_addr;

    assign bus.s_ready   = (count < CNT_W'(DEPTH));
    assign push          = bus.s_valid && bus.s_ready;
    assign push_addr     = bus.s_addr & ~(BEAT_BYTES - 1'b1);
    // A page-aligned entry never continues a burst, so bursts stay inside one 4 KB page.
    assign push_cont     = last_push_valid && (push_addr == last_push_addr + BEAT_BYTES)
                           && (push_addr[11:OFF_W] != '0);
    assign busy          = (state != IDLE) || (count != '0);
    assign bus.m_awaddr  = awaddr_q;
    assign bus.m_awlen   = awlen_q;
    assign bus.m_awsize  = 3'(OFF_W);
    assign bus.m_awburst = 2'b01;

    // Burst length: head plus the unbroken run of contiguous entries queued behind it.
    always_comb begin
        logic run;
        len_calc = 8'd1;
        run      = 1'b1;
        for (int i = 1; i < MAX_BURST; i++) begin
            if (run && (CNT_W'(i) < count) && mem_cont[rd_ptr + PTR_W'(i)]) begin
                len_calc = 8'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

`ifdef STB_WR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == B && !bus.m_bvalid && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nx      = state;
        pop           = 1'b0;
        latch         = 1'b0;
        resp_err_nx   = 1'b0;
        bus.m_awvalid = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;
        bus.m_wlast   = 1'b0;
        bus.m_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    latch    = 1'b1;
                    state_nx = AW;
                end
            end
            AW: begin
                bus.m_awvalid = 1'b1;
                if (bus.m_awready) state_nx = W;
            end
            W: begin
                bus.m_wvalid = 1'b1;
                bus.m_wdata  = mem_data[rd_ptr];
                bus.m_wstrb  = mem_strb[rd_ptr];
                bus.m_wlast  = (beats_left == 8'd1);
                if (bus.m_wready) begin
                    pop = 1'b1;
                    if (beats_left == 8'd1) state_nx = B;
                end
            end
            B: begin
                bus.m_bready = 1'b1;
                if (bus.m_bvalid) begin
                    state_nx    = IDLE;
                    resp_err_nx = (bus.m_bresp != 2'b00);
                end else if (timeout_hit) begin
                    state_nx    = IDLE;
                    resp_err_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            last_push_addr  <= '0;
            last_push_valid <= 1'b0;
            awaddr_q        <= '0;
            awlen_q         <= '0;
            beats_left      <= '0;
            resp_err        <= 1'b0;
        end else begin
            resp_err <= resp_err_nx;
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                last_push_addr  <= push_addr;
                last_push_valid <= 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                beats_left <= beats_left - 8'd1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (latch) begin
                awaddr_q   <= mem_addr[rd_ptr];
                awlen_q    <= len_calc - 8'd1;
                beats_left <= len_calc;
            end
        end
    end

    // NOTE: the entry storage has no reset; a slot is only read after count marks it as filled.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= bus.s_data;
            mem_strb[wr_ptr] <= bus.s_strb;
            mem_cont[wr_ptr] <= push_cont;
        end
    end
endmodule

// File: tb/tb_stb_axi_wr_issuer.sv
// Self-checking bench for stb_axi_wr_issuer: table-driven burst groups plus
// hand-written sequences for latency, full FIFO, error response, reset and timeout.
module tb_stb_axi_wr_issuer;
    localparam int AW_W        = 32;
    localparam int DW          = 128;
    localparam int DEPTH       = 8;
    localparam int MAX_BURST   = 4;
    localparam int TIMEOUT_CYC = 100;

    typedef struct {
        int          grp;
        logic [31:0] addr;
        logic [15:0] strb;
        logic [31:0] exp_awaddr;
        logic [7:0]  exp_awlen;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
        logic [31:0]  awaddr;
        logic [7:0]   awlen;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    bit       aw_en = 1'b0;
    bit       w_stall = 1'b0;
    bit       b_en = 1'b1;
    bit [1:0] b_resp_val = 2'b00;

    int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, b_cnt = 0;
    int order_err = 0, err_pulses = 0, bready_cycles = 0;
    logic [31:0] cur_awaddr = '0;
    logic [7:0]  cur_awlen = '0;
    beat_t beat_q[$];
    vec_t  vecs[$];

    stb_axi_wr_issuer_if #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) bus ();

    stb_axi_wr_issuer #(
        .ADDR_WIDTH (AW_W),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAX_BURST  (MAX_BURST),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] data_of(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {4{w}};
    endfunction

    task automatic add(input int g, input logic [31:0] a, input logic [15:0] s,
                       input logic [31:0] ea, input logic [7:0] el, input logic last);
        vec_t v;
        v.grp = g; v.addr = a; v.strb = s;
        v.exp_awaddr = ea; v.exp_awlen = el; v.exp_last = last;
        vecs.push_back(v);
    endtask

    task automatic push(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_addr  = a;
        bus.s_data  = d;
        bus.s_strb  = s;
        while (!bus.s_ready && n < 200) begin
            step();
            n++;
        end
        if (n == 200) check("push accept timeout", bus.s_ready, 1);
        step();
    endtask

    task automatic end_push();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        check(name, busy, 0);
    endtask

    // AXI slave responder and channel monitor; inputs change only on the falling edge.
    initial begin
        bit phase;
        phase = 1'b0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            phase = ~phase;
            bus.m_awready = aw_en;
            bus.m_wready  = !w_stall || phase;
            bus.m_bvalid  = b_en && bus.m_bready;
            bus.m_bresp   = (b_en && bus.m_bready) ? b_resp_val : 2'b00;
            if (bus.m_wvalid && aw_cnt == wlast_cnt) order_err++;
            if (resp_err) err_pulses++;
            if (bus.m_bready) bready_cycles++;
            if (bus.m_awvalid && bus.m_awready) begin
                aw_cnt++;
                cur_awaddr = bus.m_awaddr;
                cur_awlen  = bus.m_awlen;
            end
            if (bus.m_wvalid && bus.m_wready) begin
                beat_t bt;
                bt.data = bus.m_wdata; bt.strb = bus.m_wstrb; bt.last = bus.m_wlast;
                bt.awaddr = cur_awaddr; bt.awlen = cur_awlen;
                beat_q.push_back(bt);
                w_cnt++;
                if (bus.m_wlast) wlast_cnt++;
            end
            if (bus.m_bvalid && bus.m_bready) b_cnt++;
        end
    end

    initial begin
        int n, k, w0, b0, a0;
        int rows[$];

        // Rows 0 of groups 2..5 are blockers: latched alone while AW is stalled, so the
        // rest of the group is fully queued before its own burst length is decided.
        add(1, 32'h1000, 16'hFFFF, 32'h1000, 8'd0, 1'b1);
        add(2, 32'h5000, 16'hFFFF, 32'h5000, 8'd0, 1'b1);
        add(2, 32'h2040, 16'h00FF, 32'h2040, 8'd3, 1'b0);
        add(2, 32'h2050, 16'hFF00, 32'h2040, 8'd3, 1'b0);
        add(2, 32'h2060, 16'h0F0F, 32'h2040, 8'd3, 1'b0);
        add(2, 32'h2070, 16'hF0F0, 32'h2040, 8'd3, 1'b1);
        add(3, 32'h6000, 16'hFFFF, 32'h6000, 8'd0, 1'b1);
        add(3, 32'h3000, 16'hFFFF, 32'h3000, 8'd1, 1'b0);
        add(3, 32'h3013, 16'h0001, 32'h3000, 8'd1, 1'b1);
        add(3, 32'h3045, 16'h8000, 32'h3040, 8'd1, 1'b0);
        add(3, 32'h3050, 16'hFFFF, 32'h3040, 8'd1, 1'b1);
        add(4, 32'h7000, 16'hFFFF, 32'h7000, 8'd0, 1'b1);
        add(4, 32'h0FF0, 16'hFFFF, 32'h0FF0, 8'd0, 1'b1);
        add(4, 32'h1000, 16'h1234, 32'h1000, 8'd0, 1'b1);
        add(5, 32'h8000, 16'hFFFF, 32'h8000, 8'd0, 1'b1);
        add(5, 32'h4000, 16'hFFFF, 32'h4000, 8'd3, 1'b0);
        add(5, 32'h4010, 16'hFFFF, 32'h4000, 8'd3, 1'b0);
        add(5, 32'h4020, 16'hFFFF, 32'h4000, 8'd3, 1'b0);
        add(5, 32'h4030, 16'hFFFF, 32'h4000, 8'd3, 1'b1);
        add(5, 32'h4040, 16'hFFFF, 32'h4040, 8'd1, 1'b0);
        add(5, 32'h4050, 16'hFFFF, 32'h4040, 8'd1, 1'b1);

        bus.s_valid = 1'b0;
        bus.s_addr  = '0;
        bus.s_data  = '0;
        bus.s_strb  = '0;
        step();
        step();

        // Reset state
        check("rst s_ready",   bus.s_ready,   1);
        check("rst awvalid",   bus.m_awvalid, 0);
        check("rst awaddr",    bus.m_awaddr,  0);
        check("rst awlen",     bus.m_awlen,   0);
        check("rst awsize",    bus.m_awsize,  3'd4);
        check("rst awburst",   bus.m_awburst, 2'b01);
        check("rst wvalid",    bus.m_wvalid,  0);
        check("rst wlast",     bus.m_wlast,   0);
        check("rst wdata",     bus.m_wdata,   0);
        check("rst bready",    bus.m_bready,  0);
        check("rst busy",      busy,          0);
        check("rst resp_err",  resp_err,      0);
        rst = 1'b0;
        step();

        // Latency push -> m_awvalid and AW hold while stalled
        beat_q.delete();
        push(32'hB000, data_of(100), 16'hFFFF);
        end_push();
        check("lat awvalid after 1", bus.m_awvalid, 0);
        step();
        check("lat awvalid after 2", bus.m_awvalid, 1);
        check("lat awaddr", bus.m_awaddr, 32'hB000);
        check("lat awlen",  bus.m_awlen,  0);
        repeat (3) step();
        check("aw hold awvalid", bus.m_awvalid, 1);
        check("aw hold awaddr",  bus.m_awaddr,  32'hB000);
        check("no w before aw",  bus.m_wvalid,  0);
        aw_en = 1'b1;
        wait_idle("lat drain");
        check("lat beats", beat_q.size(), 1);
        if (beat_q.size() == 1) begin
            check("lat wdata", beat_q[0].data, data_of(100));
            check("lat wlast", beat_q[0].last, 1);
        end

        // Table-driven burst groups
        for (int g = 1; g <= 5; g++) begin
            beat_q.delete();
            rows.delete();
            w_stall = (g == 2);
            aw_en   = 1'b0;
            for (int i = 0; i < vecs.size(); i++)
                if (vecs[i].grp == g) rows.push_back(i);
            foreach (rows[r]) push(vecs[rows[r]].addr, data_of(rows[r]), vecs[rows[r]].strb);
            end_push();
            repeat (4) step();
            aw_en = 1'b1;
            wait_idle($sformatf("g%0d drain", g));
            check($sformatf("g%0d beat count", g), beat_q.size(), rows.size());
            k = 0;
            foreach (rows[r]) begin
                if (k < beat_q.size()) begin
                    check($sformatf("g%0d row%0d wdata", g, r),  beat_q[k].data,   data_of(rows[r]));
                    check($sformatf("g%0d row%0d wstrb", g, r),  beat_q[k].strb,   vecs[rows[r]].strb);
                    check($sformatf("g%0d row%0d wlast", g, r),  beat_q[k].last,   vecs[rows[r]].exp_last);
                    check($sformatf("g%0d row%0d awaddr", g, r), beat_q[k].awaddr, vecs[rows[r]].exp_awaddr);
                    check($sformatf("g%0d row%0d awlen", g, r),  beat_q[k].awlen,  vecs[rows[r]].exp_awlen);
                end
                k++;
            end
        end
        w_stall = 1'b0;

        // Full FIFO: s_ready drops at count==DEPTH, returns after the first W pop
        aw_en = 1'b0;
        a0 = aw_cnt;
        w0 = w_cnt;
        for (int i = 0; i < DEPTH; i++) push(32'hA000 + 32'(16 * i), data_of(200 + i), 16'hFFFF);
        end_push();
        check("full s_ready", bus.s_ready, 0);
        aw_en = 1'b1;
        n = 0;
        while (w_cnt == w0 && n < 100) begin
            step();
            n++;
        end
        check("full first pop seen", w_cnt - w0, 1);
        check("full s_ready before pop", bus.s_ready, 0);
        step();
        check("full s_ready after pop", bus.s_ready, 1);
        wait_idle("full drain");
        check("full beats", w_cnt - w0, DEPTH);
        check("full bursts", aw_cnt - a0, 3);

        // Error response: one-cycle resp_err pulse after the B handshake
        b_resp_val = 2'b10;
        b0 = b_cnt;
        push(32'hC000, data_of(300), 16'hFFFF);
        end_push();
        n = 0;
        while (b_cnt == b0 && n < 100) begin
            step();
            n++;
        end
        check("bresp handshake seen", b_cnt - b0, 1);
        check("bresp err before", resp_err, 0);
        step();
        check("bresp err pulse", resp_err, 1);
        check("bresp busy", busy, 0);
        step();
        check("bresp err cleared", resp_err, 0);
        b_resp_val = 2'b00;
        check("err pulse total", err_pulses, 1);

        // Reset mid-burst drops queued entries and the stalled burst
        aw_en = 1'b0;
        push(32'hD000, data_of(400), 16'hFFFF);
        push(32'hD010, data_of(401), 16'hFFFF);
        push(32'hD020, data_of(402), 16'hFFFF);
        end_push();
        step();
        check("mid busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid rst busy",    busy,          0);
        check("mid rst s_ready", bus.s_ready,   1);
        check("mid rst awvalid", bus.m_awvalid, 0);
        step();
        rst = 1'b0;
        aw_en = 1'b1;
        beat_q.delete();
        step();
        push(32'hE000, data_of(500), 16'h00F0);
        end_push();
        wait_idle("post rst drain");
        check("post rst beats", beat_q.size(), 1);
        if (beat_q.size() == 1) begin
            check("post rst wdata",  beat_q[0].data,   data_of(500));
            check("post rst awaddr", beat_q[0].awaddr, 32'hE000);
        end

`ifdef STB_WR_TIMEOUT_EN
        // B watchdog: no m_bvalid ever
        b_en = 1'b0;
        bready_cycles = 0;
        push(32'hF000, data_of(600), 16'hFFFF);
        end_push();
        n = 0;
        while (!resp_err && n < 400) begin
            step();
            n++;
        end
        check("timeout pulse", resp_err, 1);
        check("timeout bready cycles", bready_cycles, TIMEOUT_CYC);
        check("timeout busy", busy, 0);
        step();
        check("timeout pulse cleared", resp_err, 0);
        b_en = 1'b1;
`endif

        check("w before aw count", order_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
